otg_hpi_master: RTL and testbench

Hardware bus master for the CY7C67200 OTG Host Port Interface. It replaces software bit-banging of the HPI PIOs with a timed, parametrised read/write cycle engine driven by a valid/ready command port. It also adds a multi-word keycode shadow bank that read responses update directly, generalising the single 16-bit keycode export. It sits between the Nios-side command source (PIO/Avalon bridge) and the top-level OTG pins.

---
 rtl/otg_hpi_master_pkg.sv | 28 ++
 rtl/otg_hpi_master_if.sv | 31 +++
 rtl/otg_hpi_master_phase_timer.sv | 30 +++
 rtl/otg_hpi_master.sv | 152 +++++++++++++++
 tb/tb_otg_hpi_master.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/otg_hpi_master_pkg.sv
// Shared types and helpers for the CY7C67200 HPI bus master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } hpi_state_t;

  // HPI register select values driven on the address pins
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Width of the phase counter: enough bits for the longest phase, plus one
  function automatic int hpi_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/otg_hpi_master_if.sv
// Command/response port of the HPI bus master (valid/ready command, pulsed response).
// Latency: n/a (interface only).
// Backpressure: cmd_ready low while a transaction is in flight; responses cannot be stalled.
//
// master: command source (drives cmd_*, observes cmd_ready and rsp_*)
// slave : HPI engine    (drives cmd_ready and rsp_*)
interface otg_hpi_master_if #(
  parameter int NUM_KEY_WORDS = 1
);
  localparam int SLOT_W = $clog2(NUM_KEY_WORDS) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_addr;
  logic [15:0]       cmd_wdata;
  logic              cmd_kc;
  logic [SLOT_W-1:0] cmd_slot;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_kc, cmd_slot,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_kc, cmd_slot,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/otg_hpi_master_phase_timer.sv
// Loadable down-counter timing one HPI bus phase; done is high while the count is zero.
// Latency: done asserts load_val cycles after the load edge (load_val = phase length - 1).
// Backpressure: none; load always wins over counting.
//
// Ports: clk, rst (sync, active high), load, load_val, done
module hpi_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/otg_hpi_master.sv
// Timed HPI read/write cycle engine with a keycode shadow bank fed by read responses.
// Latency: HPI_SETUP+HPI_STROBE+HPI_HOLD cycles from accept edge to the rsp_valid edge.
// Backpressure: cmd_ready is low outside IDLE; commands offered while busy are simply not taken.
//
// Ports: clk_clk/reset_reset; cmd (command/response interface, slave side);
//        keycode_export/keycode_update (shadow bank); otg_hpi_* (chip pins).
module otg_hpi_master
  import hpi_pkg::*;
#(
  parameter int HPI_SETUP     = 1,
  parameter int HPI_STROBE    = 2,
  parameter int HPI_HOLD      = 1,
  parameter int NUM_KEY_WORDS = 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  otg_hpi_master_if.slave            cmd,
  output logic [16*NUM_KEY_WORDS-1:0] keycode_export,
  output logic                       keycode_update,
  output logic [1:0]                 otg_hpi_address_export,
  output logic                       otg_hpi_cs_export,
  output logic                       otg_hpi_r_export,
  output logic                       otg_hpi_w_export,
  output logic [15:0]                otg_hpi_data_out_port,
  output logic                       otg_hpi_data_oe,
  input  logic [15:0]                otg_hpi_data_in_port
);

  localparam int CW     = hpi_cnt_width(HPI_SETUP, HPI_STROBE, HPI_HOLD);
  localparam int SLOT_W = $clog2(NUM_KEY_WORDS) + 1;

  hpi_state_t        state, state_n;
  logic              timer_load, timer_done;
  logic [CW-1:0]     timer_val;
  logic              accept;

  logic              wr_q, kc_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        addr_q;
  logic [15:0]       data_out_q, rdata_q;
  logic              rsp_valid_q, kc_upd_q;
  logic [16*NUM_KEY_WORDS-1:0] kc_bank;

  logic cs_n_c, r_n_c, w_n_c, oe_c, ready_c;

  assign accept = cmd.cmd_valid && (state == ST_IDLE);

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (cmd.cmd_valid) state_n = ST_SETUP;
      ST_SETUP:  if (timer_done)    state_n = ST_STROBE;
      ST_STROBE: if (timer_done)    state_n = ST_HOLD;
      ST_HOLD:   if (timer_done)    state_n = ST_IDLE;
      default:                      state_n = ST_IDLE;
    endcase
  end

  // The timer is reloaded on every state change with the length of the phase being entered
  always_comb begin
    timer_load = (state_n != state);
    timer_val  = '0;
    case (state_n)
      ST_SETUP:  timer_val = CW'(HPI_SETUP - 1);
      ST_STROBE: timer_val = CW'(HPI_STROBE - 1);
      ST_HOLD:   timer_val = CW'(HPI_HOLD - 1);
      default:   timer_val = '0;
    endcase
  end

  hpi_phase_timer #(.W(CW)) u_timer (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Pin controls decoded from state only, so strobes can never overlap or escape CS
  always_comb begin
    cs_n_c  = 1'b1;
    r_n_c   = 1'b1;
    w_n_c   = 1'b1;
    oe_c    = 1'b0;
    ready_c = 1'b0;
    case (state)
      ST_IDLE:   ready_c = 1'b1;
      ST_SETUP:  begin cs_n_c = 1'b0; oe_c = wr_q; end
      ST_STROBE: begin cs_n_c = 1'b0; oe_c = wr_q; r_n_c = wr_q; w_n_c = !wr_q; end
      ST_HOLD:   begin cs_n_c = 1'b0; oe_c = wr_q; end
      default:   ready_c = 1'b0;
    endcase
  end

  // Command latch, read capture, response pulse and keycode bank
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_q        <= 1'b0;
      kc_q        <= 1'b0;
      slot_q      <= '0;
      addr_q      <= '0;
      data_out_q  <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      kc_upd_q    <= 1'b0;
      kc_bank     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      kc_upd_q    <= 1'b0;
      if (accept) begin
        wr_q   <= cmd.cmd_write;
        kc_q   <= cmd.cmd_kc;
        slot_q <= cmd.cmd_slot;
        addr_q <= cmd.cmd_addr;
        // data_out keeps the last written word; reads leave it alone
        if (cmd.cmd_write) data_out_q <= cmd.cmd_wdata;
      end
      if ((state == ST_STROBE) && timer_done && !wr_q) begin
        rdata_q <= otg_hpi_data_in_port;
      end
      if ((state == ST_HOLD) && timer_done) begin
        rsp_valid_q <= 1'b1;
        if (!wr_q && kc_q && (slot_q < SLOT_W'(NUM_KEY_WORDS))) begin
          kc_upd_q <= 1'b1;
          for (int k = 0; k < NUM_KEY_WORDS; k++) begin
            if (slot_q == SLOT_W'(k)) kc_bank[16*k +: 16] <= rdata_q;
          end
        end
      end
    end
  end

  assign cmd.cmd_ready          = ready_c;
  assign cmd.rsp_valid          = rsp_valid_q;
  assign cmd.rsp_rdata          = rdata_q;
  assign keycode_export         = kc_bank;
  assign keycode_update         = kc_upd_q;
  assign otg_hpi_address_export = addr_q;
  assign otg_hpi_cs_export      = cs_n_c;
  assign otg_hpi_r_export       = r_n_c;
  assign otg_hpi_w_export       = w_n_c;
  assign otg_hpi_data_out_port  = data_out_q;
  assign otg_hpi_data_oe        = oe_c;

endmodule

// File: tb/tb_otg_hpi_master.sv
// Directed bench for otg_hpi_master: default-timing instance with a two-word bank,
// plus a 2/3/2 timing instance for back-to-back reads.
module tb_otg_hpi_master;
  import hpi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance A: default timing, NUM_KEY_WORDS = 2
  otg_hpi_master_if #(.NUM_KEY_WORDS(2)) a_if ();
  logic [31:0] a_kc;
  logic        a_ku, a_cs, a_r, a_w, a_oe;
  logic [1:0]  a_addr;
  logic [15:0] a_dout, a_din;

  otg_hpi_master #(.NUM_KEY_WORDS(2)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .cmd(a_if),
    .keycode_export(a_kc), .keycode_update(a_ku),
    .otg_hpi_address_export(a_addr), .otg_hpi_cs_export(a_cs),
    .otg_hpi_r_export(a_r), .otg_hpi_w_export(a_w),
    .otg_hpi_data_out_port(a_dout), .otg_hpi_data_oe(a_oe),
    .otg_hpi_data_in_port(a_din)
  );

  // Instance B: timing 2/3/2, NUM_KEY_WORDS = 1
  otg_hpi_master_if #(.NUM_KEY_WORDS(1)) b_if ();
  logic [15:0] b_kc;
  logic        b_ku, b_cs, b_r, b_w, b_oe;
  logic [1:0]  b_addr;
  logic [15:0] b_dout, b_din;

  otg_hpi_master #(.HPI_SETUP(2), .HPI_STROBE(3), .HPI_HOLD(2), .NUM_KEY_WORDS(1)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .cmd(b_if),
    .keycode_export(b_kc), .keycode_update(b_ku),
    .otg_hpi_address_export(b_addr), .otg_hpi_cs_export(b_cs),
    .otg_hpi_r_export(b_r), .otg_hpi_w_export(b_w),
    .otg_hpi_data_out_port(b_dout), .otg_hpi_data_oe(b_oe),
    .otg_hpi_data_in_port(b_din)
  );

  // Per-transaction observations on instance A
  int cs_lo, r_lo, w_lo, r_first, w_first, oe_hi, rv_cnt, rv_at, ku_cnt, bad, rdy_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command on A and watch the six cycles following the accept edge.
  task automatic run_a(input logic wr, input logic [1:0] addr, input logic [15:0] wd,
                       input logic kc, input logic [1:0] slot);
    cs_lo = 0; r_lo = 0; w_lo = 0; r_first = 0; w_first = 0; oe_hi = 0;
    rv_cnt = 0; rv_at = 0; ku_cnt = 0; bad = 0; rdy_hi = 0;
    @(negedge clk);
    a_if.cmd_valid = 1'b1; a_if.cmd_write = wr; a_if.cmd_addr = addr;
    a_if.cmd_wdata = wd;   a_if.cmd_kc = kc;    a_if.cmd_slot = slot;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) a_if.cmd_valid = 1'b0;
      if (!a_cs) cs_lo++;
      if (!a_r) begin r_lo++; if (r_first == 0) r_first = c; end
      if (!a_w) begin w_lo++; if (w_first == 0) w_first = c; end
      if (a_oe) oe_hi++;
      if (a_if.rsp_valid) begin rv_cnt++; rv_at = c; end
      if (a_ku) ku_cnt++;
      if ((!a_r && !a_w) || ((!a_r || !a_w) && a_cs)) bad++;
      if (c <= 4 && a_if.cmd_ready) rdy_hi++;
    end
  endtask

  int bc_lo, bc_hi_mid, bc_hi_at, b_rv_cnt, b_rv_first, b_rv_last, b_rdy_hi, b_rdy_gap;
  logic [15:0] rd1, rd2;

  initial begin
    a_if.cmd_valid = 0; a_if.cmd_write = 0; a_if.cmd_addr = 0;
    a_if.cmd_wdata = 0; a_if.cmd_kc = 0; a_if.cmd_slot = 0; a_din = 16'h0;
    b_if.cmd_valid = 0; b_if.cmd_write = 0; b_if.cmd_addr = 0;
    b_if.cmd_wdata = 0; b_if.cmd_kc = 0; b_if.cmd_slot = 0; b_din = 16'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs",    a_cs, 1);
    check("rst_r",     a_r, 1);
    check("rst_w",     a_w, 1);
    check("rst_addr",  a_addr, 0);
    check("rst_dout",  a_dout, 0);
    check("rst_oe",    a_oe, 0);
    check("rst_ready", a_if.cmd_ready, 1);
    check("rst_rv",    a_if.rsp_valid, 0);
    check("rst_rdata", a_if.rsp_rdata, 0);
    check("rst_kc",    a_kc, 0);
    check("rst_ku",    a_ku, 0);
    check("rst_b_cs",  b_cs, 1);
    rst = 1'b0;

    // Write at defaults: addr=2, wdata=0x1234
    run_a(1'b1, HPI_ADDR, 16'h1234, 1'b0, 2'd0);
    check("wr_cs_low",   cs_lo, 4);
    check("wr_w_low",    w_lo, 2);
    check("wr_w_first",  w_first, 2);
    check("wr_r_low",    r_lo, 0);
    check("wr_oe",       oe_hi, 4);
    check("wr_rv_cnt",   rv_cnt, 1);
    check("wr_rv_at",    rv_at, 5);
    check("wr_busy",     rdy_hi, 0);
    check("wr_overlap",  bad, 0);
    check("wr_addr",     a_addr, 2);
    check("wr_dout",     a_dout, 16'h1234);
    check("wr_rdata",    a_if.rsp_rdata, 0);

    // Read at defaults: addr=0, pins hold 0xBEEF
    a_din = 16'hBEEF;
    run_a(1'b0, HPI_DATA, 16'h0000, 1'b0, 2'd0);
    check("rd_r_low",    r_lo, 2);
    check("rd_r_first",  r_first, 2);
    check("rd_w_low",    w_lo, 0);
    check("rd_oe",       oe_hi, 0);
    check("rd_cs_low",   cs_lo, 4);
    check("rd_rv_at",    rv_at, 5);
    check("rd_rdata",    a_if.rsp_rdata, 16'hBEEF);
    check("rd_ku",       ku_cnt, 0);
    check("rd_dout_hold", a_dout, 16'h1234);

    // Keycode capture into slots 1 then 0
    a_din = 16'h0504;
    run_a(1'b0, HPI_DATA, 16'h0, 1'b1, 2'd1);
    check("kc1_ku",      ku_cnt, 1);
    check("kc1_bank",    a_kc, 32'h0504_0000);
    a_din = 16'h001A;
    run_a(1'b0, HPI_DATA, 16'h0, 1'b1, 2'd0);
    check("kc0_ku",      ku_cnt, 1);
    check("kc0_bank",    a_kc, 32'h0504_001A);

    // Out-of-range slot: response fires, bank untouched
    a_din = 16'hFFFF;
    run_a(1'b0, HPI_DATA, 16'h0, 1'b1, 2'd2);
    check("kc2_rv_cnt",  rv_cnt, 1);
    check("kc2_ku",      ku_cnt, 0);
    check("kc2_bank",    a_kc, 32'h0504_001A);
    check("kc2_rdata",   a_if.rsp_rdata, 16'hFFFF);

    // Write with kc=1 never captures
    run_a(1'b1, HPI_MAILBOX, 16'h7777, 1'b1, 2'd0);
    check("kcw_ku",      ku_cnt, 0);
    check("kcw_bank",    a_kc, 32'h0504_001A);

    // Back-to-back reads on B with cmd_valid held high
    bc_lo = 0; bc_hi_mid = 0; bc_hi_at = 0; b_rv_cnt = 0; b_rv_first = 0; b_rv_last = 0;
    b_rdy_hi = 0; b_rdy_gap = 0; rd1 = 0; rd2 = 0;
    @(negedge clk);
    b_din = 16'h1111;
    b_if.cmd_valid = 1'b1; b_if.cmd_write = 1'b0; b_if.cmd_addr = HPI_STATUS;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (!b_cs) bc_lo++;
      else if (c <= 15) begin bc_hi_mid++; bc_hi_at = c; end
      if (b_if.rsp_valid) begin
        b_rv_cnt++;
        if (b_rv_first == 0) b_rv_first = c;
        b_rv_last = c;
      end
      if (c == 8)  rd1 = b_if.rsp_rdata;
      if (c == 16) rd2 = b_if.rsp_rdata;
      if (c <= 15 && c != 8 && b_if.cmd_ready) b_rdy_hi++;
      if (c == 8 && b_if.cmd_ready) b_rdy_gap++;
      if (c == 8) b_din = 16'h2222;
      if (c == 9) b_if.cmd_valid = 1'b0;
    end
    check("b2b_cs_low",   bc_lo, 14);
    check("b2b_cs_gap",   bc_hi_mid, 1);
    check("b2b_gap_at",   bc_hi_at, 8);
    check("b2b_busy",     b_rdy_hi, 0);
    check("b2b_ready_gap", b_rdy_gap, 1);
    check("b2b_rv_cnt",   b_rv_cnt, 2);
    check("b2b_rv_first", b_rv_first, 8);
    check("b2b_rv_last",  b_rv_last, 16);
    check("b2b_rd1",      rd1, 16'h1111);
    check("b2b_rd2",      rd2, 16'h2222);

    // Reset in the second STROBE cycle of a keycode read on A
    a_din = 16'h9999;
    @(negedge clk);
    a_if.cmd_valid = 1'b1; a_if.cmd_write = 1'b0; a_if.cmd_addr = HPI_DATA;
    a_if.cmd_kc = 1'b1; a_if.cmd_slot = 2'd0;
    @(negedge clk);
    a_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_strobe",  a_r, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_cs",      a_cs, 1);
    check("mid_r",       a_r, 1);
    check("mid_w",       a_w, 1);
    check("mid_oe",      a_oe, 0);
    check("mid_kc",      a_kc, 0);
    check("mid_rv",      a_if.rsp_valid, 0);
    check("mid_rdata",   a_if.rsp_rdata, 0);
    check("mid_dout",    a_dout, 0);
    check("mid_ready",   a_if.cmd_ready, 1);
    rst = 1'b0;
    a_if.cmd_valid = 1'b1; a_if.cmd_write = 1'b1; a_if.cmd_addr = HPI_MAILBOX;
    a_if.cmd_wdata = 16'hA5A5; a_if.cmd_kc = 1'b0;
    @(negedge clk);
    a_if.cmd_valid = 1'b0;
    check("post_cs",     a_cs, 0);
    check("post_addr",   a_addr, 1);
    check("post_oe",     a_oe, 1);
    rv_cnt = 0; rv_at = 0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      if (a_if.rsp_valid) begin rv_cnt++; rv_at = c; end
    end
    check("post_rv_cnt", rv_cnt, 1);
    check("post_rv_at",  rv_at, 5);
    check("post_dout",   a_dout, 16'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
